// File: rtl/input_pkg.sv
// Shared keycode map, direction/state types and the keycode decoder for the
// two-player input arbiter.
package input_pkg;

    localparam int unsigned KEYCODE_W = 8;

    localparam logic [KEYCODE_W-1:0] KEY_W     = 8'h1A;
    localparam logic [KEYCODE_W-1:0] KEY_S     = 8'h16;
    localparam logic [KEYCODE_W-1:0] KEY_A     = 8'h04;
    localparam logic [KEYCODE_W-1:0] KEY_D     = 8'h07;
    localparam logic [KEYCODE_W-1:0] KEY_UP    = 8'h52;
    localparam logic [KEYCODE_W-1:0] KEY_DOWN  = 8'h51;
    localparam logic [KEYCODE_W-1:0] KEY_LEFT  = 8'h50;
    localparam logic [KEYCODE_W-1:0] KEY_RIGHT = 8'h4F;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P1   = 2'd1,
        OWN_P2   = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        dir_t   dir;
    } key_decode_t;

    // Map a HID keycode to its owning player and direction; unmapped codes have no owner.
    function automatic key_decode_t decode_key(input logic [KEYCODE_W-1:0] code);
        key_decode_t d;
        d.owner = OWN_NONE;
        d.dir   = DIR_UP;
        case (code)
            KEY_W:     begin d.owner = OWN_P1; d.dir = DIR_UP;    end
            KEY_S:     begin d.owner = OWN_P1; d.dir = DIR_DOWN;  end
            KEY_A:     begin d.owner = OWN_P1; d.dir = DIR_LEFT;  end
            KEY_D:     begin d.owner = OWN_P1; d.dir = DIR_RIGHT; end
            KEY_UP:    begin d.owner = OWN_P2; d.dir = DIR_UP;    end
            KEY_DOWN:  begin d.owner = OWN_P2; d.dir = DIR_DOWN;  end
            KEY_LEFT:  begin d.owner = OWN_P2; d.dir = DIR_LEFT;  end
            KEY_RIGHT: begin d.owner = OWN_P2; d.dir = DIR_RIGHT; end
            default:   ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/player_key_fsm.sv
// Per-player press/auto-repeat FSM with hold counter and a one-entry
// latest-wins move slot on a valid/ready handshake.
module player_key_fsm
    import input_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 10000000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic owned,
    input  logic new_key,
    input  dir_t dir,
    input  logic game_active,
    input  logic ready,
    output logic valid,
    output dir_t dir_out
);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emit_c;
    logic             valid_d;
    dir_t             dir_d;

    // Next-state, hold counter and move-slot update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        emit_c  = 1'b0;
        valid_d = valid;
        dir_d   = dir_out;

        if (!game_active) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (owned && new_key) begin
                        state_d = ST_PRESS;
                        emit_c  = 1'b1;
                    end
                end
                ST_PRESS, ST_REPEAT: begin
                    if (!owned) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (new_key) begin
                        // Direction change restarts the initial-delay timer.
                        state_d = ST_PRESS;
                        emit_c  = 1'b1;
                        cnt_d   = '0;
                    end else if ((state_q == ST_PRESS  && cnt_q == DELAY_LAST) ||
                                 (state_q == ST_REPEAT && cnt_q == RATE_LAST)) begin
                        state_d = ST_REPEAT;
                        emit_c  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (!game_active) begin
            valid_d = 1'b0;
        end else if (emit_c) begin
            valid_d = 1'b1;
            dir_d   = dir;
        end else if (valid && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid   <= 1'b0;
            dir_out <= DIR_UP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid   <= valid_d;
            dir_out <= dir_d;
        end
    end

endmodule

// File: rtl/player_input_arbiter.sv
// Splits the SoC HID keycode between two players (WASD / arrows) and turns
// presses into per-player move commands with auto-repeat.
module player_input_arbiter
    import input_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 10000000,
    parameter int unsigned CNT_W        =
        $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE)
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [KEYCODE_W-1:0] keycode,
    input  logic                 game_active,
    output logic                 p1_move_valid,
    output logic [1:0]           p1_move_dir,
    input  logic                 p1_move_ready,
    output logic                 p2_move_valid,
    output logic [1:0]           p2_move_dir,
    input  logic                 p2_move_ready
);

    logic [KEYCODE_W-1:0] key_q;
    logic                 armed_q;
    logic                 new_key_c;
    key_decode_t          dec_c;
    dir_t                 p1_dir;
    dir_t                 p2_dir;

    // armed_q masks the first sample after reset so a key held through reset
    // needs a re-press, just like after game_active rises.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            key_q   <= keycode;
            armed_q <= 1'b1;
        end
    end

    assign new_key_c = armed_q && (keycode != key_q);
    assign dec_c     = decode_key(keycode);

    player_key_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .CNT_W        (CNT_W)
    ) u_p1 (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .owned       (dec_c.owner == OWN_P1),
        .new_key     (new_key_c),
        .dir         (dec_c.dir),
        .game_active (game_active),
        .ready       (p1_move_ready),
        .valid       (p1_move_valid),
        .dir_out     (p1_dir)
    );

    player_key_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .CNT_W        (CNT_W)
    ) u_p2 (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .owned       (dec_c.owner == OWN_P2),
        .new_key     (new_key_c),
        .dir         (dec_c.dir),
        .game_active (game_active),
        .ready       (p2_move_ready),
        .valid       (p2_move_valid),
        .dir_out     (p2_dir)
    );

    assign p1_move_dir = p1_dir;
    assign p2_move_dir = p2_dir;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Bench for player_input_arbiter: decode table plus hand-written hold, hand-off,
// back-pressure, game_active and reset sequences, checked through a move scoreboard.
module tb_player_input_arbiter;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [7:0] keycode;
    logic       game_active;
    logic       p1_move_valid;
    logic [1:0] p1_move_dir;
    logic       p1_move_ready;
    logic       p2_move_valid;
    logic [1:0] p2_move_dir;
    logic       p2_move_ready;

    player_input_arbiter #(
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .keycode       (keycode),
        .game_active   (game_active),
        .p1_move_valid (p1_move_valid),
        .p1_move_dir   (p1_move_dir),
        .p1_move_ready (p1_move_ready),
        .p2_move_valid (p2_move_valid),
        .p2_move_dir   (p2_move_dir),
        .p2_move_ready (p2_move_ready)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int cyc;
        int dir;
    } exp_t;

    typedef struct {
        logic [7:0] key;
        int         owner;
        int         dir;
    } vec_t;

    exp_t p1_q[$];
    exp_t p2_q[$];
    vec_t vecs[12];
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   k;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int player, input int c, input int d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        if (player == 1) p1_q.push_back(e);
        else             p2_q.push_back(e);
    endtask

    // Every accepted handshake must match the oldest expected move of that player.
    task automatic sample();
        exp_t e;
        if (p1_move_valid && p1_move_ready) begin
            if (p1_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL p1_unexpected_move: got dir %0d at cycle %0d, expected none",
                         p1_move_dir, cyc);
            end else begin
                e = p1_q.pop_front();
                check("p1_move_cycle", cyc, e.cyc);
                check("p1_move_dir", int'(p1_move_dir), e.dir);
            end
        end
        if (p2_move_valid && p2_move_ready) begin
            if (p2_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL p2_unexpected_move: got dir %0d at cycle %0d, expected none",
                         p2_move_dir, cyc);
            end else begin
                e = p2_q.pop_front();
                check("p2_move_cycle", cyc, e.cyc);
                check("p2_move_dir", int'(p2_move_dir), e.dir);
            end
        end
    endtask

    // Sample on the falling edge, then return #1 after the next rising edge.
    task automatic tick();
        @(negedge clk_clk);
        sample();
        @(posedge clk_clk);
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        vecs[0]  = '{8'h1A, 1, 0};
        vecs[1]  = '{8'h16, 1, 1};
        vecs[2]  = '{8'h04, 1, 2};
        vecs[3]  = '{8'h07, 1, 3};
        vecs[4]  = '{8'h52, 2, 0};
        vecs[5]  = '{8'h51, 2, 1};
        vecs[6]  = '{8'h50, 2, 2};
        vecs[7]  = '{8'h4F, 2, 3};
        vecs[8]  = '{8'h00, 0, 0};
        vecs[9]  = '{8'h05, 0, 0};
        vecs[10] = '{8'h4E, 0, 0};
        vecs[11] = '{8'h53, 0, 0};

        cyc           = 0;
        n_cmp         = 0;
        n_fail        = 0;
        reset_reset_n = 1'b0;
        keycode       = 8'h00;
        game_active   = 1'b1;
        p1_move_ready = 1'b1;
        p2_move_ready = 1'b1;

        ticks(3);
        check("reset_p1_valid", int'(p1_move_valid), 0);
        check("reset_p2_valid", int'(p2_move_valid), 0);
        check("reset_p1_dir", int'(p1_move_dir), 0);
        check("reset_p2_dir", int'(p2_move_dir), 0);
        reset_reset_n = 1'b1;
        ticks(2);

        // Decode table: one press per keycode, released after one cycle.
        for (int i = 0; i < 12; i++) begin
            k = cyc;
            keycode = vecs[i].key;
            if (vecs[i].owner == 1) push(1, k + 1, vecs[i].dir);
            if (vecs[i].owner == 2) push(2, k + 1, vecs[i].dir);
            tick();
            check("table_p1_valid", int'(p1_move_valid), (vecs[i].owner == 1) ? 1 : 0);
            check("table_p2_valid", int'(p2_move_valid), (vecs[i].owner == 2) ? 1 : 0);
            if (vecs[i].owner == 1) check("table_p1_dir", int'(p1_move_dir), vecs[i].dir);
            if (vecs[i].owner == 2) check("table_p2_dir", int'(p2_move_dir), vecs[i].dir);
            keycode = 8'h00;
            ticks(2);
        end

        // Press and release after 3 cycles: a single move.
        k = cyc;
        keycode = 8'h1A;
        push(1, k + 1, 0);
        ticks(3);
        keycode = 8'h00;
        ticks(3);

        // Hold right arrow: press move, then delay 8, then every 4.
        k = cyc;
        keycode = 8'h4F;
        push(2, k + 1, 3);
        push(2, k + 9, 3);
        push(2, k + 13, 3);
        push(2, k + 17, 3);
        push(2, k + 21, 3);
        push(2, k + 25, 3);
        push(2, k + 29, 3);
        run_until(k + 30);
        keycode = 8'h00;
        ticks(3);

        // Direction change restarts the delay, then hand-off to player 2.
        k = cyc;
        keycode = 8'h04;
        push(1, k + 1, 2);
        run_until(k + 5);
        keycode = 8'h07;
        push(1, k + 6, 3);
        push(1, k + 14, 3);
        run_until(k + 15);
        keycode = 8'h51;
        push(2, k + 16, 1);
        tick();
        check("handoff_p1_valid", int'(p1_move_valid), 0);
        check("handoff_p2_valid", int'(p2_move_valid), 1);
        keycode = 8'h00;
        ticks(3);

        // Back-pressure: latest move wins, one acceptance.
        p1_move_ready = 1'b0;
        k = cyc;
        keycode = 8'h1A;
        tick();
        check("bp_first_valid", int'(p1_move_valid), 1);
        check("bp_first_dir", int'(p1_move_dir), 0);
        tick();
        keycode = 8'h16;
        tick();
        check("bp_latest_valid", int'(p1_move_valid), 1);
        check("bp_latest_dir", int'(p1_move_dir), 1);
        keycode = 8'h00;
        tick();
        check("bp_held_dir", int'(p1_move_dir), 1);
        p1_move_ready = 1'b1;
        push(1, k + 4, 1);
        tick();
        p1_move_ready = 1'b0;
        check("bp_after_accept_valid", int'(p1_move_valid), 0);
        ticks(2);
        p1_move_ready = 1'b1;
        ticks(2);

        // game_active drop mid-repeat flushes; held key needs a re-press.
        k = cyc;
        keycode = 8'h52;
        push(2, k + 1, 0);
        push(2, k + 9, 0);
        run_until(k + 13);
        check("ga_valid_before_drop", int'(p2_move_valid), 1);
        game_active   = 1'b0;
        p2_move_ready = 1'b0;
        tick();
        check("ga_valid_after_drop", int'(p2_move_valid), 0);
        p2_move_ready = 1'b1;
        ticks(3);
        game_active = 1'b1;
        ticks(20);
        keycode = 8'h00;
        ticks(2);
        k = cyc;
        keycode = 8'h52;
        push(2, k + 1, 0);
        tick();
        check("ga_repress_valid", int'(p2_move_valid), 1);
        keycode = 8'h00;
        ticks(3);

        // Asynchronous reset during repeat; a key held through reset is ignored.
        k = cyc;
        keycode = 8'h52;
        push(2, k + 1, 0);
        push(2, k + 9, 0);
        run_until(k + 13);
        check("rst_valid_before", int'(p2_move_valid), 1);
        reset_reset_n = 1'b0;
        #2;
        check("rst_async_p2_valid", int'(p2_move_valid), 0);
        check("rst_async_p1_dir", int'(p1_move_dir), 0);
        ticks(2);
        reset_reset_n = 1'b1;
        ticks(20);
        check("rst_no_move_p2_valid", int'(p2_move_valid), 0);
        keycode = 8'h00;
        ticks(3);

        check("p1_pending_moves", p1_q.size(), 0);
        check("p2_pending_moves", p2_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
